// File: rtl/fir_sample_packer.sv
// fir_sample_packer: collects P_SAMPLES multi-channel samples into one wide
// output beat. The k-th sample of a group lands in lane P_SAMPLES-1-k, so
// lane 0 holds the newest sample and lane P_SAMPLES-1 the oldest.
//
// Optional feature: define FIR_PACKER_FLUSH_EN to add a 'flush' input that
// closes a partial group early, with the unfilled lanes left at zero.
//
// Ports:
//   clk       sole clock, rising edge
//   nrst      asynchronous active-low reset
//   flush     (FIR_PACKER_FLUSH_EN only) single-cycle partial-group close
//   s_tvalid  input sample valid
//   s_tready  input sample accepted when high together with s_tvalid
//   s_tdata   one sample per channel; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   m_tvalid  packed beat valid
//   m_tready  downstream accepts the beat
//   m_tdata   packed beat; channel c lane j at
//             [(c*P_SAMPLES+j)*DATA_WIDTH +: DATA_WIDTH]
module fir_sample_packer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned P_SAMPLES  = 8
) (
  input  logic                                     clk,
  input  logic                                     nrst,
`ifdef FIR_PACKER_FLUSH_EN
  input  logic                                     flush,
`endif
  input  logic                                     s_tvalid,
  output logic                                     s_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]           s_tdata,
  output logic                                     m_tvalid,
  input  logic                                     m_tready,
  output logic [CHANNELS*P_SAMPLES*DATA_WIDTH-1:0] m_tdata
);

  localparam int unsigned BEAT_W = CHANNELS * P_SAMPLES * DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(P_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(P_SAMPLES);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [BEAT_W-1:0] asm_q, asm_d;
  logic [BEAT_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;

  logic              accept;
  logic              out_free;
  logic              flush_fire;
  logic              complete;
  logic [CNT_W-1:0]  post_count;
  logic [BEAT_W-1:0] beat;

  // Ready only reflects registered fill state and reset.
  assign s_tready = nrst && (count_q < CNT_FULL);
  assign m_tvalid = valid_q;
  assign m_tdata  = out_q;

  // State registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: assemble the incoming sample, then decide whether the beat
  // (fresh or already pending) moves to the output register this edge.
  always_comb begin
    accept     = s_tvalid && s_tready;
    out_free   = !valid_q || m_tready;
    // A new group starts from all-zero lanes so flushed beats pad with zeros.
    beat       = (count_q == '0) ? '0 : asm_q;
    post_count = count_q;
    flush_fire = 1'b0;
    complete   = 1'b0;
    count_d    = count_q;
    asm_d      = asm_q;
    out_d      = out_q;
    valid_d    = valid_q;

    if (accept) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned j = 0; j < P_SAMPLES; j++) begin
          if (count_q == CNT_W'(P_SAMPLES - 1 - j)) begin
            beat[(c*P_SAMPLES + j)*DATA_WIDTH +: DATA_WIDTH] =
              s_tdata[c*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      post_count = count_q + CNT_W'(1);
    end

`ifdef FIR_PACKER_FLUSH_EN
    flush_fire = flush && (post_count != '0) && (post_count != CNT_FULL);
`endif

    // A held full beat (count already full) also takes this path.
    complete = (post_count == CNT_FULL) || flush_fire;

    count_d = post_count;
    asm_d   = beat;

    // Drain: output empties unless a new beat replaces it below.
    if (valid_q && m_tready) begin
      valid_d = 1'b0;
      out_d   = '0;
    end

    if (complete && out_free) begin
      out_d   = beat;
      valid_d = 1'b1;
      count_d = '0;
      asm_d   = '0;
    end else if (complete) begin
      count_d = CNT_FULL;
    end
  end

endmodule

// File: tb/tb_fir_sample_packer.sv
module tb_fir_sample_packer;

  localparam int unsigned DW     = 16;
  localparam int unsigned CH     = 2;
  localparam int unsigned P      = 8;
  localparam int unsigned SW     = CH * DW;
  localparam int unsigned BEAT_W = CH * P * DW;

  logic              clk;
  logic              nrst;
  logic              s_tvalid;
  logic              s_tready;
  logic [SW-1:0]     s_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [BEAT_W-1:0] m_tdata;
`ifdef FIR_PACKER_FLUSH_EN
  logic              flush;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int low_seen = 0;

  fir_sample_packer #(.DATA_WIDTH(DW), .CHANNELS(CH), .P_SAMPLES(P)) dut (
    .clk      (clk),
    .nrst     (nrst),
`ifdef FIR_PACKER_FLUSH_EN
    .flush    (flush),
`endif
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BEAT_W-1:0] act,
                       input logic [BEAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: the open group as a queue of samples, one pending
  // complete beat, and the output register contents.
  logic [SW-1:0]     cur[$];
  logic              pend = 1'b0;
  logic [BEAT_W-1:0] pbeat = '0;
  logic              outv = 1'b0;
  logic [BEAT_W-1:0] obeat = '0;

  function automatic logic [BEAT_W-1:0] pack_cur();
    logic [BEAT_W-1:0] b;
    logic [SW-1:0]     smp;
    b = '0;
    for (int k = 0; k < cur.size(); k++) begin
      smp = cur[k];
      for (int c = 0; c < int'(CH); c++)
        b[(c*int'(P) + int'(P) - 1 - k)*int'(DW) +: DW] = smp[c*int'(DW) +: DW];
    end
    return b;
  endfunction

  always @(posedge clk or negedge nrst) begin
    logic acc, hs, free, done, fl_in;
    logic [BEAT_W-1:0] nb;
    if (!nrst) begin
      cur.delete();
      pend  = 1'b0;
      pbeat = '0;
      outv  = 1'b0;
      obeat = '0;
    end else begin
`ifdef FIR_PACKER_FLUSH_EN
      fl_in = flush;
`else
      fl_in = 1'b0;
`endif
      acc  = s_tvalid && !pend;
      hs   = outv && m_tready;
      free = !outv || m_tready;
      done = 1'b0;
      nb   = '0;
      if (hs) hs_cnt++;
      if (acc) cur.push_back(s_tdata);
      if (pend) begin
        done = 1'b1;
        nb   = pbeat;
      end else if (cur.size() == int'(P) || (fl_in && cur.size() > 0)) begin
        done = 1'b1;
        nb   = pack_cur();
        cur.delete();
      end
      if (done && free) begin
        outv  = 1'b1;
        obeat = nb;
        pend  = 1'b0;
      end else begin
        if (done) begin
          pend  = 1'b1;
          pbeat = nb;
        end
        if (hs) begin
          outv  = 1'b0;
          obeat = '0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("m_tvalid", BEAT_W'(m_tvalid), BEAT_W'(outv));
    check("m_tdata", m_tdata, outv ? obeat : '0);
    check("s_tready", BEAT_W'(s_tready), BEAT_W'(nrst && !pend));
    if (nrst && s_tready !== 1'b1) low_seen++;
  end

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [SW-1:0] d);
    logic r;
    int   n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    n = 0;
    r = 1'b0;
    while (!r && n < 200) begin
      @(negedge clk) r = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=%0d expected=<200", n);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, h0, l0, acc;
    logic r;
    nrst     = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
`ifdef FIR_PACKER_FLUSH_EN
    flush    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", BEAT_W'(m_tvalid), '0);
    check("rst_s_tready", BEAT_W'(s_tready), '0);
    check("rst_m_tdata", m_tdata, '0);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_tready", BEAT_W'(s_tready), BEAT_W'(1'b1));

    // Eight samples, downstream always ready.
    for (int i = 1; i <= 8; i++) send({16'(i), 16'(16'h0100 + i)});
    check("b1_valid", BEAT_W'(m_tvalid), BEAT_W'(1'b1));
    check("b1_ch0_lane7", BEAT_W'(m_tdata[7*16 +: 16]), BEAT_W'(16'h0101));
    check("b1_ch0_lane0", BEAT_W'(m_tdata[0 +: 16]), BEAT_W'(16'h0108));
    check("b1_ch1_lane7", BEAT_W'(m_tdata[15*16 +: 16]), BEAT_W'(16'h0001));
    check("b1_beat", m_tdata,
          {128'h0001_0002_0003_0004_0005_0006_0007_0008,
           128'h0101_0102_0103_0104_0105_0106_0107_0108});
    idle(3);

    // 24 back-to-back samples: three beats, no bubbles.
    c0 = cyc;
    h0 = hs_cnt;
    l0 = low_seen;
    for (int i = 0; i < 24; i++) send(SW'(32'hA000_0000 + 32'(i * 3)));
    check("stream_cycles", BEAT_W'(cyc - c0), BEAT_W'(24));
    idle(3);
    check("stream_beats", BEAT_W'(hs_cnt - h0), BEAT_W'(3));
    check("stream_no_stall", BEAT_W'(low_seen - l0), '0);

    // Backpressure: 20 cycles of streaming with m_tready low.
    m_tready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = {16'(16'h2001 + acc), 16'(16'h1001 + acc)};
      @(negedge clk) r = s_tready;
      @(posedge clk);
      #1;
      if (r) acc++;
    end
    check("bp_accepted", BEAT_W'(acc), BEAT_W'(16));
    check("bp_s_tready", BEAT_W'(s_tready), '0);
    check("bp_hold_valid", BEAT_W'(m_tvalid), BEAT_W'(1'b1));
    check("bp_hold_beat", m_tdata,
          {128'h2001_2002_2003_2004_2005_2006_2007_2008,
           128'h1001_1002_1003_1004_1005_1006_1007_1008});
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_b2_valid", BEAT_W'(m_tvalid), BEAT_W'(1'b1));
    check("bp_b2_beat", m_tdata,
          {128'h2009_200a_200b_200c_200d_200e_200f_2010,
           128'h1009_100a_100b_100c_100d_100e_100f_1010});
    idle(3);

    // Reset mid-group discards the partial beat.
    for (int i = 0; i < 5; i++) send(SW'(32'hDEAD_BE00 + 32'(i)));
    nrst = 1'b0;
    @(negedge clk);
    check("mid_rst_m_tvalid", BEAT_W'(m_tvalid), '0);
    check("mid_rst_s_tready", BEAT_W'(s_tready), '0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    for (int i = 0; i < 8; i++) send({16'(16'h4001 + i), 16'(16'h3001 + i)});
    check("rst_clean_beat", m_tdata,
          {128'h4001_4002_4003_4004_4005_4006_4007_4008,
           128'h3001_3002_3003_3004_3005_3006_3007_3008});
    idle(3);

`ifdef FIR_PACKER_FLUSH_EN
    // Three samples, then flush together with a fourth.
    for (int i = 0; i < 3; i++) send({16'(16'h6001 + i), 16'(16'h5001 + i)});
    flush = 1'b1;
    send({16'h6004, 16'h5004});
    flush = 1'b0;
    check("flush_valid", BEAT_W'(m_tvalid), BEAT_W'(1'b1));
    check("flush_beat", m_tdata,
          {128'h6001_6002_6003_6004_0000_0000_0000_0000,
           128'h5001_5002_5003_5004_0000_0000_0000_0000});
    idle(3);
    h0 = hs_cnt;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_empty_no_beat", BEAT_W'(m_tvalid), '0);
    idle(3);
    check("flush_empty_no_hs", BEAT_W'(hs_cnt - h0), '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
